// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_ctrl_if
//   Bundles the request/response handshakes of the instruction cache and the
//   load-store buffer, the pipeline flush, the UART backpressure flag and the
//   byte-wide RAM bus used by mem_ctrl.
//   master : environment side (requesters, flush source, RAM)
//   slave  : the memory controller
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface mem_ctrl_if;
  // iCache fetch channel
  logic        in_from_iCache_valid;
  logic [31:0] in_from_iCache_addr;
  logic        out_to_iCache_valid;
  logic [31:0] out_to_iCache_ins;
  // load-store buffer channel
  logic        in_from_lsb_valid;
  logic        in_from_lsb_wr;
  logic [31:0] in_from_lsb_addr;
  logic [1:0]  in_from_lsb_size;
  logic [31:0] in_from_lsb_data;
  logic        out_to_lsb_valid;
  logic [31:0] out_to_lsb_data;
  // flush and IO backpressure
  logic        in_from_rob_clear;
  logic        io_buffer_full;
  // RAM bus
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport master (
    output in_from_iCache_valid, in_from_iCache_addr,
    input  out_to_iCache_valid, out_to_iCache_ins,
    output in_from_lsb_valid, in_from_lsb_wr, in_from_lsb_addr,
    output in_from_lsb_size, in_from_lsb_data,
    input  out_to_lsb_valid, out_to_lsb_data,
    output in_from_rob_clear, io_buffer_full, mem_din,
    input  mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  in_from_iCache_valid, in_from_iCache_addr,
    output out_to_iCache_valid, out_to_iCache_ins,
    input  in_from_lsb_valid, in_from_lsb_wr, in_from_lsb_addr,
    input  in_from_lsb_size, in_from_lsb_data,
    output out_to_lsb_valid, out_to_lsb_data,
    input  in_from_rob_clear, io_buffer_full, mem_din,
    output mem_dout, mem_a, mem_wr
  );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_ctrl
//   Serialises iCache word fetches and LSB loads/stores (1/2/4 bytes) onto a
//   byte-wide synchronous RAM, one byte per cycle, arbitrating between the two
//   requesters and aborting speculative reads on a pipeline flush. Read data
//   is assembled little-endian and returned with a one-cycle response pulse.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous reset, active low
//     rdy  - global enable; low freezes all state and masks strobes
//     bus  - mem_ctrl_if.slave (requests, responses, flush, RAM bus)
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module mem_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    LOAD   = 2'd2,
    STORE  = 2'd3
  } state_t;

  localparam logic        GRANT_IC  = 1'b0;
  localparam logic        GRANT_LSB = 1'b1;
  localparam logic [31:0] IO_BASE   = 32'h0003_0000;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        ic_valid_q, ic_valid_d;
  logic [31:0] ic_ins_q, ic_ins_d;
  logic        lsb_valid_q, lsb_valid_d;
  logic [31:0] lsb_data_q, lsb_data_d;

  // Arbitration
  logic        store_blocked;
  logic        ic_req;
  logic        lsb_req;
  logic        pick_lsb;
  logic [2:0]  lsb_len;

  // Datapath helpers
  logic [2:0]  next_k;       // index of the byte handled at this edge, plus one
  logic [31:0] next_addr;
  logic [31:0] asm_next;
  logic [31:0] store_shift;

  // An IO store waits while the UART buffer is full; iCache may use the slot.
  assign store_blocked = bus.in_from_lsb_valid && bus.in_from_lsb_wr &&
                         (bus.in_from_lsb_addr >= IO_BASE) && bus.io_buffer_full;
  assign ic_req   = bus.in_from_iCache_valid;
  assign lsb_req  = bus.in_from_lsb_valid && !store_blocked;
  assign pick_lsb = lsb_req && (!ic_req || (last_grant_q == GRANT_IC));

  always_comb begin
    case (bus.in_from_lsb_size)
      2'd0:    lsb_len = 3'd1;
      2'd1:    lsb_len = 3'd2;
      default: lsb_len = 3'd4;
    endcase
  end

  assign next_k      = {1'b0, step_q} + 3'd1;
  assign next_addr   = addr_q + {29'd0, next_k};
  assign store_shift = wdata_q >> {next_k[1:0], 3'b000};

  always_comb begin
    asm_next = asm_q;
    asm_next[{step_q, 3'b000} +: 8] = bus.mem_din;
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    len_d        = len_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    asm_d        = asm_q;
    last_grant_d = last_grant_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    ic_valid_d   = 1'b0;
    ic_ins_d     = ic_ins_q;
    lsb_valid_d  = 1'b0;
    lsb_data_d   = lsb_data_q;

    case (state_q)
      IDLE: begin
        if (!bus.in_from_rob_clear && (ic_req || lsb_req)) begin
          step_d = 2'd0;
          asm_d  = 32'd0;
          if (pick_lsb) begin
            last_grant_d = GRANT_LSB;
            addr_d       = bus.in_from_lsb_addr;
            len_d        = lsb_len;
            wdata_d      = bus.in_from_lsb_data;
            mem_a_d      = bus.in_from_lsb_addr;
            if (bus.in_from_lsb_wr) begin
              state_d    = STORE;
              mem_dout_d = bus.in_from_lsb_data[7:0];
              mem_wr_d   = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end else begin
            last_grant_d = GRANT_IC;
            state_d      = IFETCH;
            addr_d       = bus.in_from_iCache_addr;
            len_d        = 3'd4;
            mem_a_d      = bus.in_from_iCache_addr;
          end
        end
      end

      IFETCH, LOAD: begin
        if (bus.in_from_rob_clear) begin
          // Speculative read is dropped, even on its final byte.
          state_d = IDLE;
          mem_a_d = 32'd0;
        end else begin
          asm_d = asm_next;
          if (next_k == len_q) begin
            state_d = IDLE;
            mem_a_d = 32'd0;
            if (state_q == IFETCH) begin
              ic_valid_d = 1'b1;
              ic_ins_d   = asm_next;
            end else begin
              lsb_valid_d = 1'b1;
              lsb_data_d  = asm_next;
            end
          end else begin
            mem_a_d = next_addr;
            step_d  = step_q + 2'd1;
          end
        end
      end

      STORE: begin
        // Stores are committed and ignore the flush.
        if (next_k == len_q) begin
          state_d     = IDLE;
          mem_a_d     = 32'd0;
          mem_dout_d  = 8'd0;
          mem_wr_d    = 1'b0;
          lsb_valid_d = 1'b1;
          lsb_data_d  = 32'd0;
        end else begin
          mem_a_d    = next_addr;
          mem_dout_d = store_shift[7:0];
          step_d     = step_q + 2'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      step_q       <= 2'd0;
      len_q        <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      asm_q        <= 32'd0;
      last_grant_q <= GRANT_LSB;
      mem_a_q      <= 32'd0;
      mem_dout_q   <= 8'd0;
      mem_wr_q     <= 1'b0;
      ic_valid_q   <= 1'b0;
      ic_ins_q     <= 32'd0;
      lsb_valid_q  <= 1'b0;
      lsb_data_q   <= 32'd0;
    end else if (rdy) begin
      state_q      <= state_d;
      step_q       <= step_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      asm_q        <= asm_d;
      last_grant_q <= last_grant_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      ic_valid_q   <= ic_valid_d;
      ic_ins_q     <= ic_ins_d;
      lsb_valid_q  <= lsb_valid_d;
      lsb_data_q   <= lsb_data_d;
    end
  end

  // Strobes are masked while frozen; a held pulse reappears when rdy returns.
  assign bus.mem_wr              = mem_wr_q & rdy;
  assign bus.out_to_iCache_valid = ic_valid_q & rdy;
  assign bus.out_to_lsb_valid    = lsb_valid_q & rdy;
  assign bus.mem_a               = mem_a_q;
  assign bus.mem_dout            = mem_dout_q;
  assign bus.out_to_iCache_ins   = ic_ins_q;
  assign bus.out_to_lsb_data     = lsb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_ctrl
//   Directed self-checking bench for mem_ctrl with a combinational-read RAM
//   model (byte for mem_a is available before the following edge).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

  logic clk;
  logic rst;
  logic rdy;
  int   n_checks;
  int   n_errors;

  logic [7:0] ram [0:4095];

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  assign bus.mem_din = ram[bus.mem_a[11:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic lsb_req(input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] data);
    bus.in_from_lsb_valid = 1'b1;
    bus.in_from_lsb_wr    = wr;
    bus.in_from_lsb_size  = size;
    bus.in_from_lsb_addr  = addr;
    bus.in_from_lsb_data  = data;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    rdy = 1'b1;
    bus.in_from_iCache_valid = 1'b0;
    bus.in_from_iCache_addr  = 32'd0;
    bus.in_from_lsb_valid    = 1'b0;
    bus.in_from_lsb_wr       = 1'b0;
    bus.in_from_lsb_addr     = 32'd0;
    bus.in_from_lsb_size     = 2'd0;
    bus.in_from_lsb_data     = 32'd0;
    bus.in_from_rob_clear    = 1'b0;
    bus.io_buffer_full       = 1'b0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h200] = 8'h11; ram[12'h201] = 8'h22; ram[12'h202] = 8'h33; ram[12'h203] = 8'h44;
    ram[12'hFFE] = 8'hA1; ram[12'hFFF] = 8'hB2; ram[12'h000] = 8'hC3; ram[12'h001] = 8'hD4;

    // Reset state
    repeat (2) tick();
    chk("rst_mem_a",     bus.mem_a, 32'd0);
    chk("rst_mem_wr",    {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_mem_dout",  {24'd0, bus.mem_dout}, 32'd0);
    chk("rst_ic_valid",  {31'd0, bus.out_to_iCache_valid}, 32'd0);
    chk("rst_ic_ins",    bus.out_to_iCache_ins, 32'd0);
    chk("rst_lsb_valid", {31'd0, bus.out_to_lsb_valid}, 32'd0);
    chk("rst_lsb_data",  bus.out_to_lsb_data, 32'd0);
    rst = 1'b1;
    tick();

    // Tie after reset: iCache, then LSB, then iCache
    bus.in_from_iCache_valid = 1'b1;
    bus.in_from_iCache_addr  = 32'h100;
    lsb_req(1'b0, 2'd0, 32'h200, 32'd0);
    tick();
    chk("tie1_ic_addr", bus.mem_a, 32'h100);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("fetch_addr", bus.mem_a, 32'h100 + k);
      chk("fetch_no_pulse", {31'd0, bus.out_to_iCache_valid}, 32'd0);
    end
    tick();
    chk("fetch_addr_end", bus.mem_a, 32'd0);
    chk("fetch_pulse", {31'd0, bus.out_to_iCache_valid}, 32'd1);
    chk("fetch_ins", bus.out_to_iCache_ins, 32'h0000_0513);
    tick();
    chk("tie2_lsb_addr", bus.mem_a, 32'h200);
    chk("fetch_pulse_once", {31'd0, bus.out_to_iCache_valid}, 32'd0);
    tick();
    chk("byte_load_pulse", {31'd0, bus.out_to_lsb_valid}, 32'd1);
    chk("byte_load_data", bus.out_to_lsb_data, 32'h11);
    chk("byte_load_addr_end", bus.mem_a, 32'd0);
    tick();
    chk("tie3_ic_addr", bus.mem_a, 32'h100);
    bus.in_from_lsb_valid = 1'b0;
    repeat (3) tick();
    tick();
    chk("fetch2_pulse", {31'd0, bus.out_to_iCache_valid}, 32'd1);
    bus.in_from_iCache_valid = 1'b0;
    tick();
    chk("fetch2_pulse_once", {31'd0, bus.out_to_iCache_valid}, 32'd0);

    // Half-word store
    lsb_req(1'b1, 2'd1, 32'h2000, 32'hAABB_CCDD);
    tick();
    chk("st_wr0",   {31'd0, bus.mem_wr}, 32'd1);
    chk("st_a0",    bus.mem_a, 32'h2000);
    chk("st_d0",    {24'd0, bus.mem_dout}, 32'hDD);
    tick();
    chk("st_wr1",   {31'd0, bus.mem_wr}, 32'd1);
    chk("st_a1",    bus.mem_a, 32'h2001);
    chk("st_d1",    {24'd0, bus.mem_dout}, 32'hCC);
    tick();
    chk("st_wr_end",   {31'd0, bus.mem_wr}, 32'd0);
    chk("st_a_end",    bus.mem_a, 32'd0);
    chk("st_d_end",    {24'd0, bus.mem_dout}, 32'd0);
    chk("st_pulse",    {31'd0, bus.out_to_lsb_valid}, 32'd1);
    chk("st_data",     bus.out_to_lsb_data, 32'd0);
    bus.in_from_lsb_valid = 1'b0;
    tick();
    chk("st_pulse_once", {31'd0, bus.out_to_lsb_valid}, 32'd0);

    // Clear mid-fetch after step 2
    bus.in_from_iCache_valid = 1'b1;
    bus.in_from_iCache_addr  = 32'h100;
    repeat (3) tick();
    chk("clr_pre_addr", bus.mem_a, 32'h102);
    bus.in_from_rob_clear = 1'b1;
    tick();
    chk("clr_addr", bus.mem_a, 32'd0);
    chk("clr_no_pulse", {31'd0, bus.out_to_iCache_valid}, 32'd0);
    bus.in_from_rob_clear    = 1'b0;
    bus.in_from_iCache_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("clr_no_pulse_later", {31'd0, bus.out_to_iCache_valid}, 32'd0);
      chk("clr_idle_addr", bus.mem_a, 32'd0);
    end

    // Clear during a store: store still completes
    lsb_req(1'b1, 2'd0, 32'h2010, 32'h0000_005A);
    tick();
    chk("stclr_d0", {24'd0, bus.mem_dout}, 32'h5A);
    bus.in_from_rob_clear = 1'b1;
    tick();
    chk("stclr_wr_end", {31'd0, bus.mem_wr}, 32'd0);
    chk("stclr_pulse", {31'd0, bus.out_to_lsb_valid}, 32'd1);
    bus.in_from_rob_clear = 1'b0;
    bus.in_from_lsb_valid = 1'b0;
    tick();

    // IO backpressure
    bus.io_buffer_full = 1'b1;
    lsb_req(1'b1, 2'd0, 32'h0003_0000, 32'h77);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("io_blk_wr", {31'd0, bus.mem_wr}, 32'd0);
      chk("io_blk_a",  bus.mem_a, 32'd0);
    end
    bus.io_buffer_full = 1'b0;
    tick();
    chk("io_wr", {31'd0, bus.mem_wr}, 32'd1);
    chk("io_a",  bus.mem_a, 32'h0003_0000);
    chk("io_d",  {24'd0, bus.mem_dout}, 32'h77);
    tick();
    chk("io_pulse", {31'd0, bus.out_to_lsb_valid}, 32'd1);
    bus.in_from_lsb_valid = 1'b0;
    tick();

    // Just below the IO range is not held back
    bus.io_buffer_full = 1'b1;
    lsb_req(1'b1, 2'd0, 32'h0002_FFFF, 32'h66);
    tick();
    chk("below_io_wr", {31'd0, bus.mem_wr}, 32'd1);
    chk("below_io_a",  bus.mem_a, 32'h0002_FFFF);
    tick();
    chk("below_io_pulse", {31'd0, bus.out_to_lsb_valid}, 32'd1);
    bus.in_from_lsb_valid = 1'b0;
    tick();

    // Blocked IO store yields the slot to iCache
    lsb_req(1'b1, 2'd0, 32'h0003_0004, 32'h55);
    bus.in_from_iCache_valid = 1'b1;
    bus.in_from_iCache_addr  = 32'h100;
    tick();
    chk("blk_ic_addr", bus.mem_a, 32'h100);
    chk("blk_ic_wr",   {31'd0, bus.mem_wr}, 32'd0);
    bus.in_from_iCache_valid = 1'b0;
    bus.in_from_lsb_valid    = 1'b0;
    bus.io_buffer_full       = 1'b0;
    repeat (3) tick();
    tick();
    chk("blk_ic_pulse", {31'd0, bus.out_to_iCache_valid}, 32'd1);
    chk("blk_ic_ins",   bus.out_to_iCache_ins, 32'h0000_0513);
    tick();

    // rdy low for 3 cycles mid word load
    lsb_req(1'b0, 2'd2, 32'h200, 32'd0);
    tick();
    tick();
    chk("rdy_pre_addr", bus.mem_a, 32'h201);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rdy_hold_addr", bus.mem_a, 32'h201);
      chk("rdy_hold_nopulse", {31'd0, bus.out_to_lsb_valid}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    chk("rdy_addr2", bus.mem_a, 32'h202);
    tick();
    chk("rdy_addr3", bus.mem_a, 32'h203);
    tick();
    chk("rdy_load_pulse", {31'd0, bus.out_to_lsb_valid}, 32'd1);
    chk("rdy_load_data",  bus.out_to_lsb_data, 32'h4433_2211);
    bus.in_from_lsb_valid = 1'b0;
    rdy = 1'b0;
    #1;
    chk("rdy_pulse_masked", {31'd0, bus.out_to_lsb_valid}, 32'd0);
    rdy = 1'b1;
    #1;
    chk("rdy_pulse_back", {31'd0, bus.out_to_lsb_valid}, 32'd1);
    tick();
    chk("rdy_pulse_done", {31'd0, bus.out_to_lsb_valid}, 32'd0);

    // Address wrap across 2^32
    lsb_req(1'b0, 2'd3, 32'hFFFF_FFFE, 32'd0);
    tick();
    chk("wrap_a0", bus.mem_a, 32'hFFFF_FFFE);
    tick();
    chk("wrap_a1", bus.mem_a, 32'hFFFF_FFFF);
    tick();
    chk("wrap_a2", bus.mem_a, 32'h0000_0000);
    tick();
    chk("wrap_a3", bus.mem_a, 32'h0000_0001);
    tick();
    chk("wrap_pulse", {31'd0, bus.out_to_lsb_valid}, 32'd1);
    chk("wrap_data",  bus.out_to_lsb_data, 32'hD4C3_B2A1);
    bus.in_from_lsb_valid = 1'b0;
    tick();

    // Reset mid-fetch
    bus.in_from_iCache_valid = 1'b1;
    bus.in_from_iCache_addr  = 32'h100;
    tick();
    tick();
    chk("rstmid_pre_addr", bus.mem_a, 32'h101);
    rst = 1'b0;
    #1;
    chk("rstmid_addr",     bus.mem_a, 32'd0);
    chk("rstmid_ic_valid", {31'd0, bus.out_to_iCache_valid}, 32'd0);
    chk("rstmid_ic_ins",   bus.out_to_iCache_ins, 32'd0);
    bus.in_from_iCache_valid = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rstmid_no_resp", {31'd0, bus.out_to_iCache_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
